// File: rtl/biu_line_req_issue.sv
// biu_line_req_issue
// Pops line-refill addresses from the BIU request FIFO and splits each line
// into BEATS single-beat read requests. Outstanding reads are limited by a
// credit counter; in-order read responses are counted to flag line completion.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   fifo_valid        FIFO head entry available
//   fifo_data         FIFO head entry (line address, low OFF bits ignored)
//   fifo_pop          pop FIFO head this cycle (combinational)
//   bus_req_valid     read request valid (registered)
//   bus_req_addr      read beat byte address (registered)
//   bus_req_ready     bus accepts the request
//   bus_rsp_valid     one read beat returned, in order
//   line_done         pulses with the last response beat of a line (combinational)
//   busy              line in progress, request pending, or reads outstanding
//   err               sticky: response received with nothing outstanding
module biu_line_req_issue #(
    parameter int unsigned DW         = 32,
    parameter int unsigned BEATS      = 4,
    parameter int unsigned BEAT_BYTES = 4,
    parameter int unsigned MAX_OS     = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fifo_valid,
    input  logic [DW-1:0] fifo_data,
    output logic          fifo_pop,
    output logic          bus_req_valid,
    output logic [DW-1:0] bus_req_addr,
    input  logic          bus_req_ready,
    input  logic          bus_rsp_valid,
    output logic          line_done,
    output logic          busy,
    output logic          err
);

    localparam int unsigned LINE = BEATS * BEAT_BYTES;
    localparam int unsigned OFF  = $clog2(LINE);
    localparam int unsigned BOFF = $clog2(BEAT_BYTES);
    localparam int unsigned BCW  = $clog2(BEATS);
    localparam int unsigned OSW  = $clog2(MAX_OS + 1);
    localparam int unsigned BW   = DW - OFF;

    // State
    logic            line_active_q, line_active_d;
    logic [BW-1:0]   base_q,        base_d;
    logic [BCW-1:0]  beat_cnt_q,    beat_cnt_d;
    logic            req_valid_q,   req_valid_d;
    logic [DW-1:0]   req_addr_q,    req_addr_d;
    logic [OSW-1:0]  os_cnt_q,      os_cnt_d;
    logic [BCW-1:0]  rsp_cnt_q,     rsp_cnt_d;
    logic            err_q,         err_d;

    // Shared decode
    logic slot_free;
    logic credit_ok;
    logic load;
    logic os_nz;
    logic rsp_ok;

    assign slot_free = ~req_valid_q | bus_req_ready;
    // Credit uses the registered count only; a same-cycle response frees it next cycle.
    assign credit_ok = os_cnt_q < OSW'(MAX_OS);
    // Gating with rst keeps fifo_pop low while the block is held in reset.
    assign load      = slot_free & credit_ok & (line_active_q | fifo_valid) & ~rst;
    assign os_nz     = os_cnt_q != '0;
    assign rsp_ok    = bus_rsp_valid & os_nz;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_active_q <= 1'b0;
            base_q        <= '0;
            beat_cnt_q    <= '0;
            req_valid_q   <= 1'b0;
            req_addr_q    <= '0;
            os_cnt_q      <= '0;
            rsp_cnt_q     <= '0;
            err_q         <= 1'b0;
        end else begin
            line_active_q <= line_active_d;
            base_q        <= base_d;
            beat_cnt_q    <= beat_cnt_d;
            req_valid_q   <= req_valid_d;
            req_addr_q    <= req_addr_d;
            os_cnt_q      <= os_cnt_d;
            rsp_cnt_q     <= rsp_cnt_d;
            err_q         <= err_d;
        end
    end

    // Next-state logic
    always_comb begin
        line_active_d = line_active_q;
        base_d        = base_q;
        beat_cnt_d    = beat_cnt_q;
        req_valid_d   = req_valid_q;
        req_addr_d    = req_addr_q;
        os_cnt_d      = os_cnt_q;
        rsp_cnt_d     = rsp_cnt_q;
        err_d         = err_q;

        if (load) begin
            req_valid_d = 1'b1;
            if (line_active_q) begin
                // Beat offset lives below OFF, so it can never carry into the base.
                req_addr_d = DW'({base_q, beat_cnt_q}) << BOFF;
                beat_cnt_d = beat_cnt_q + BCW'(1);
                if (beat_cnt_q == BCW'(BEATS - 1)) begin
                    line_active_d = 1'b0;
                end
            end else begin
                base_d        = fifo_data[DW-1:OFF];
                req_addr_d    = (fifo_data >> OFF) << OFF;
                beat_cnt_d    = BCW'(1);
                line_active_d = 1'b1;
            end
        end else if (req_valid_q && bus_req_ready) begin
            req_valid_d = 1'b0;
        end

        // Outstanding count: +1 per load, -1 per legitimate response.
        case ({load, rsp_ok})
            2'b10:   os_cnt_d = os_cnt_q + OSW'(1);
            2'b01:   os_cnt_d = os_cnt_q - OSW'(1);
            default: os_cnt_d = os_cnt_q;
        endcase

        if (rsp_ok) begin
            rsp_cnt_d = rsp_cnt_q + BCW'(1);
        end

        if (bus_rsp_valid && !os_nz) begin
            err_d = 1'b1;
        end
    end

    // Outputs
    always_comb begin
        fifo_pop      = load & ~line_active_q;
        line_done     = rsp_ok & (rsp_cnt_q == BCW'(BEATS - 1));
        busy          = line_active_q | req_valid_q | os_nz;
        bus_req_valid = req_valid_q;
        bus_req_addr  = req_addr_q;
        err           = err_q;
    end

endmodule

// File: doc/biu_line_req_issue.md
Name: biu_line_req_issue

Overview:
- Consumer stage directly downstream of the BIU 2-in/1-out request FIFO.
- Pops one line-refill address per FIFO entry and splits it into BEATS single-beat read requests on the BIU bus.
- Applies valid/ready backpressure and limits outstanding reads with a credit counter.
- Counts in-order read responses to flag line completion.

Parameters:
DW, 32, width of FIFO entry and bus address (byte address)
BEATS, 4, beats per line; power of two, >= 2
BEAT_BYTES, 4, bytes per beat; power of two
MAX_OS, 4, maximum outstanding (issued, not responded) beats; >= 1

Ports:
clk  input  1  clock
rst  input  1  reset; asynchronous, active-high
fifo_valid  input  1  FIFO has an entry (FIFO dout_valid)
fifo_data  input  DW  FIFO head entry, line address (FIFO dout)
fifo_pop  output  1  pop FIFO head this cycle; combinational
bus_req_valid  output  1  read request valid; registered
bus_req_addr  output  DW  read beat byte address; registered
bus_req_ready  input  1  bus accepts request
bus_rsp_valid  input  1  one read beat returned; responses arrive in order
line_done  output  1  pulse with the last response beat of a line; combinational
busy  output  1  line in progress, request pending, or reads outstanding
err  output  1  sticky: response received with zero outstanding

Behaviour:
- LINE = BEATS*BEAT_BYTES; OFF = log2(LINE); BOFF = log2(BEAT_BYTES).
- State registers: line_active, base[DW-1:OFF], beat_cnt (log2 BEATS bits, next beat to issue), req_valid, req_addr.
- More state: os_cnt (clog2(MAX_OS+1) bits), rsp_cnt (log2 BEATS bits), err.
- Reset values: all zero, so bus_req_valid=0, bus_req_addr=0, fifo_pop=0, line_done=0, busy=0, err=0.
- Slot free: slot_free = ~req_valid | bus_req_ready.
- Credit: credit_ok = os_cnt < MAX_OS. It uses the current os_cnt only; a same-cycle response does not free a credit until the next cycle.
- Load: load = slot_free & credit_ok & (line_active | fifo_valid).
- Load source when line_active:
  - req_addr <= {base, beat_cnt, BOFF zeros}.
  - beat_cnt <= beat_cnt+1 (wraps to 0).
  - line_active <= 0 when beat_cnt == BEATS-1.
- Load source when ~line_active (new line):
  - fifo_pop=1 this cycle only.
  - base <= fifo_data[DW-1:OFF]; fifo_data[OFF-1:0] is ignored.
  - req_addr <= {fifo_data[DW-1:OFF], OFF zeros}.
  - beat_cnt <= 1; line_active <= 1.
- fifo_pop is asserted only under this condition; never while line_active.
- Any load sets req_valid <= 1.
- Handshake without load: req_valid <= 0.
- Stall: while req_valid & ~bus_req_ready, req_valid and req_addr hold stable. A request is never withdrawn.
- Latency: fifo_pop at cycle T gives beat 0 valid at T+1.
- Throughput: one beat per cycle with ready high and credit available, including across line boundaries. The next line's pop happens in the cycle that loads over the previous last beat's handshake, so there is no bubble.
- Credit accounting: os_cnt increments on load and decrements on bus_rsp_valid. Both in the same cycle leave it unchanged. os_cnt never exceeds MAX_OS.
- Response tracking:
  - On bus_rsp_valid: rsp_cnt <= rsp_cnt+1 (wraps).
  - line_done = bus_rsp_valid & (rsp_cnt == BEATS-1) & (os_cnt != 0).
- Spurious response: bus_rsp_valid with os_cnt == 0 sets err. err clears only on reset. os_cnt stays 0, rsp_cnt is unchanged, line_done=0.
- busy = line_active | req_valid | (os_cnt != 0).
- Address arithmetic: beat offset is confined to the line and never carries into base. Upper bits pass through unchanged, so address 0xFFFF_FFF0 stays in its line.
- Reset mid-operation: the current line, pending request and counters are discarded. The bus is reset together. Responses arriving after reset with os_cnt == 0 set err.

Test Plan:
1. Single line, defaults, ready=1, fifo_data=0x0000_1234 at T -> fifo_pop=1 at T only. bus_req_addr = 0x1230, 0x1234, 0x1238, 0x123C at T+1..T+4, each with valid=1. Valid=0 at T+5. busy=1 until 4 responses return; line_done on the 4th response.
2. Backpressure: ready=0 for 3 cycles while beat 1 (0x1234) is valid -> addr and valid stable for all 3 cycles. 0x1238 appears the cycle after ready returns high. No extra pop.
3. Credit limit, MAX_OS=2, no responses -> 0x1230 and 0x1234 issued, then valid=0 and os_cnt=2. Apply one bus_rsp_valid -> the next cycle loads 0x1238.
4. Back-to-back lines: 0x100 and 0x200 queued, ready=1, MAX_OS=8 -> addrs 0x100..0x10C then 0x200..0x20C on 8 consecutive cycles. Second fifo_pop coincides with the cycle issuing 0x200's load.
5. Simultaneous response and handshake at os_cnt=MAX_OS=4 -> no load that cycle, os_cnt=3 next cycle, load the cycle after. Spurious bus_rsp_valid after all responses -> err=1 and stays 1; line_done=0.
6. Assert rst mid-line after beat 1 is issued -> all outputs 0 asynchronously. After deassert, a new entry 0x40 issues 0x40..0x4C normally.
